fpu_addsub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle floating-point add/sub unit among NUM_REQ requesters. It latches the winning requester's operands and drives the unit's start/op/data_a/data_b, waits for the unit's ready, then returns the result to that requester with a one-cycle done pulse. A watchdog aborts hung operations, and the unit is drained before the next issue. The block sits between the requester clients and the single FP add/sub instance.

---
 rtl/fpu_addsub_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle FP add/sub unit among
// NUM_REQ requesters: grant, issue handshake, wait, result return, watchdog, drain.
module fpu_addsub_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [31:0]            result,
    output logic                   err,
    output logic                   fpu_start,
    output logic                   fpu_op,
    output logic [31:0]            fpu_a,
    output logic [31:0]            fpu_b,
    input  logic                   fpu_busy,
    input  logic                   fpu_ready,
    input  logic [31:0]            fpu_data,
    output logic                   arb_busy,
    output logic [IDX_W-1:0]       cur_id,
    output logic [15:0]            op_count
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  cur_id_q, cur_id_d;
    logic              fpu_op_q, fpu_op_d;
    logic [31:0]       fpu_a_q, fpu_a_d;
    logic [31:0]       fpu_b_q, fpu_b_d;
    logic [31:0]       result_q, result_d;
    logic              err_q, err_d;
    logic [15:0]       op_count_q, op_count_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [IDX_W-1:0]  pick_idx, cand_idx;
    logic              pick_found;
    logic              grant_ok;
    logic              tmo_hit;

    // Search starts just after the last winner, so it has lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand_idx = IDX_W'((32'(last_q) + off) % NUM_REQ);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign grant_ok = (state_q == S_IDLE) && pick_found && !fpu_busy && !fpu_ready;
    // Counter value one before TIMEOUT-1: the abort lands on the cycle it would reach it.
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 2));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_ok) state_d = S_ISSUE;
            S_ISSUE: begin
                if (tmo_hit)       state_d = S_DONE;
                else if (fpu_busy) state_d = S_WAIT;
            end
            S_WAIT:  if (fpu_ready || tmo_hit) state_d = S_DONE;
            S_DONE:  state_d = err_q ? S_DRAIN : S_IDLE;
            S_DRAIN: if (!fpu_busy && !fpu_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_d     = last_q;
        cur_id_d   = cur_id_q;
        fpu_op_d   = fpu_op_q;
        fpu_a_d    = fpu_a_q;
        fpu_b_d    = fpu_b_q;
        result_d   = result_q;
        err_d      = err_q;
        op_count_d = op_count_q;
        tmo_d      = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    last_d   = pick_idx;
                    cur_id_d = pick_idx;
                    fpu_op_d = req_op[pick_idx];
                    fpu_a_d  = req_a[32*pick_idx +: 32];
                    fpu_b_d  = req_b[32*pick_idx +: 32];
                    tmo_d    = '0;
                end
            end
            S_ISSUE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                // Counted on entry to DONE so the count already includes the op being returned.
                if (fpu_ready) begin
                    result_d = fpu_data;
                    err_d    = 1'b0;
                    if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
                end else if (tmo_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q     <= IDX_W'(NUM_REQ - 1);
            cur_id_q   <= '0;
            fpu_op_q   <= 1'b0;
            fpu_a_q    <= '0;
            fpu_b_q    <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            op_count_q <= '0;
            tmo_q      <= '0;
        end else begin
            last_q     <= last_d;
            cur_id_q   <= cur_id_d;
            fpu_op_q   <= fpu_op_d;
            fpu_a_q    <= fpu_a_d;
            fpu_b_q    <= fpu_b_d;
            result_q   <= result_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
            tmo_q      <= tmo_d;
        end
    end

    // Grant is a same-cycle pulse; operands are sampled at the end of that cycle.
    always_comb begin
        gnt       = '0;
        done      = '0;
        fpu_start = (state_q == S_ISSUE);
        arb_busy  = (state_q != S_IDLE);
        if (grant_ok && !reset) gnt[pick_idx] = 1'b1;
        if (state_q == S_DONE)  done[cur_id_q] = 1'b1;
    end

    assign result   = result_q;
    assign err      = err_q;
    assign fpu_op   = fpu_op_q;
    assign fpu_a    = fpu_a_q;
    assign fpu_b    = fpu_b_q;
    assign cur_id   = cur_id_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: behavioural FP unit, per-cycle reference model
// of the arbiter, and directed scenarios with hand-computed expectations.
module tb_fpu_addsub_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned TMO = 64;
    localparam int unsigned LAT = 8;

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req = '0, req_op = '0;
    logic [32*N-1:0]   req_a = '0, req_b = '0;
    logic [N-1:0]      gnt, done;
    logic [31:0]       result, fpu_a, fpu_b;
    logic              err, fpu_start, fpu_op, arb_busy;
    logic              fpu_busy, fpu_ready;
    logic [31:0]       fpu_data;
    logic [IW-1:0]     cur_id;
    logic [15:0]       op_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc_n++;

    fpu_addsub_arbiter #(.NUM_REQ(N), .IDX_W(IW), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .req(req), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .gnt(gnt), .done(done),
        .result(result), .err(err), .fpu_start(fpu_start), .fpu_op(fpu_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_busy(fpu_busy), .fpu_ready(fpu_ready),
        .fpu_data(fpu_data), .arb_busy(arb_busy), .cur_id(cur_id), .op_count(op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Single-precision add/sub for normal operands via double-precision reals.
    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) - 11'd127 + 11'd1023, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_addsub(input logic op, input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = sp2real(a);
        rb = sp2real(b);
        return real2sp(op ? ra - rb : ra + rb);
    endfunction

    // Behavioural FP unit: busy for LAT cycles, then a one-cycle ready with data.
    logic stuck = 1'b0, force_busy = 1'b0, fb_busy = 1'b0, fb_hang = 1'b0, fb_op = 1'b0;
    logic [31:0] fb_a = '0, fb_b = '0;
    int fb_cnt = 0;
    assign fpu_busy = fb_busy | force_busy;

    initial begin
        fpu_ready = 1'b0;
        fpu_data  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                fb_busy = 1'b0; fpu_ready = 1'b0; fpu_data = '0;
            end else begin
                fpu_ready = 1'b0;
                if (fb_busy && fb_hang) begin
                    if (!stuck) fb_busy = 1'b0;
                end else if (fb_busy) begin
                    fb_cnt--;
                    if (fb_cnt == 0) begin
                        fb_busy = 1'b0; fpu_ready = 1'b1;
                        fpu_data = fp_addsub(fb_op, fb_a, fb_b);
                    end
                end else if (fpu_start) begin
                    fb_busy = 1'b1; fb_hang = stuck; fb_cnt = LAT;
                    fb_op = fpu_op; fb_a = fpu_a; fb_b = fpu_b;
                end
            end
        end
    end

    // Reference model: one operation at a time, tracked by flags and cycle age.
    bit m_inop = 0, m_started = 0, m_done = 0, m_drain = 0;
    int m_last = N - 1, m_id = 0, m_age = 0, m_count = 0, pk;
    logic m_op = 1'b0, m_err = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [N-1:0] e_gnt, e_done;
    logic e_start, e_abusy, m_idle;

    always @(negedge clock) begin
        #1;
        if (reset) begin
            m_inop = 0; m_started = 0; m_done = 0; m_drain = 0;
            m_last = N - 1; m_id = 0; m_age = 0; m_count = 0;
            m_op = 1'b0; m_err = 1'b0; m_a = '0; m_b = '0; m_res = '0;
        end
        m_idle = !m_inop && !m_done && !m_drain;
        e_gnt  = '0;
        pk     = -1;
        if (!reset && m_idle && (req != '0) && !fpu_busy && !fpu_ready) begin
            for (int off = 1; off <= N; off++) begin
                if (pk < 0 && req[(m_last + off) % N]) pk = (m_last + off) % N;
            end
            e_gnt[pk] = 1'b1;
        end
        e_done = '0;
        if (m_done) e_done[m_id] = 1'b1;
        e_start = m_inop && !m_started;
        e_abusy = !m_idle;

        check("gnt", 32'(gnt), 32'(e_gnt));
        check("done", 32'(done), 32'(e_done));
        check("fpu_start", 32'(fpu_start), 32'(e_start));
        check("arb_busy", 32'(arb_busy), 32'(e_abusy));
        check("cur_id", 32'(cur_id), m_id);
        check("op_count", 32'(op_count), m_count);
        check("fpu_op", 32'(fpu_op), 32'(m_op));
        check("fpu_a", fpu_a, m_a);
        check("fpu_b", fpu_b, m_b);
        if (m_done) begin
            check("result", result, m_res);
            check("err", 32'(err), 32'(m_err));
        end

        if (!reset) begin
            if (m_done) begin
                m_done  = 0;
                m_drain = m_err;
            end else if (m_drain) begin
                if (!fpu_busy && !fpu_ready) m_drain = 0;
            end else if (m_inop) begin
                if (m_started && fpu_ready) begin
                    m_inop = 0; m_done = 1; m_err = 1'b0;
                    m_res = fp_addsub(m_op, m_a, m_b);
                    if (m_count < 65535) m_count++;
                end else if (m_age == TMO - 1) begin
                    m_inop = 0; m_done = 1; m_err = 1'b1; m_res = '0;
                end else if (!m_started && fpu_busy) begin
                    m_started = 1;
                end
                m_age++;
            end else if (pk >= 0) begin
                m_id = pk; m_last = pk;
                m_op = req_op[pk]; m_a = req_a[32*pk +: 32]; m_b = req_b[32*pk +: 32];
                m_inop = 1; m_started = 0; m_age = 1;
            end
        end
    end

    task automatic set_op(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
        req_op[i] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Checks the current cycle first, so call it right after driving req at a negedge.
    task automatic wait_gnt(output int idx, output int at);
        idx = -1; at = -1;
        for (int k = 0; k < 300; k++) begin
            #2;
            if (gnt != '0) begin
                at = cyc_n;
                for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
                break;
            end
            @(negedge clock);
        end
        if (idx < 0) begin
            n_tests++; n_fail++;
            $display("FAIL gnt_wait: no grant within 300 cycles (cycle %0d)", cyc_n);
        end
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            #2;
            if (done != '0) begin
                at = cyc_n;
                break;
            end
        end
        if (at < 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_wait: no done within 300 cycles (cycle %0d)", cyc_n);
        end
    endtask

    initial begin
        int idx, g, d;
        int order[5];
        int exp_rr[5] = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clock);
        #2;
        check("rst_arb_busy", 32'(arb_busy), 0);
        check("rst_op_count", 32'(op_count), 0);
        @(negedge clock);
        reset = 1'b0;

        // 1.0 + 2.0 from requester 0
        @(negedge clock);
        set_op(0, 1'b0, F1, F2);
        req = 4'b0001;
        wait_gnt(idx, g);
        check("t1_gnt", 32'(gnt), 32'h1);
        @(negedge clock);
        req = '0;
        wait_done(d);
        check("t1_done", 32'(done), 32'h1);
        check("t1_result", result, 32'h40400000);
        check("t1_err", 32'(err), 0);
        check("t1_count", 32'(op_count), 1);

        // 3.0 - 1.0 from requester 2
        @(negedge clock);
        set_op(2, 1'b1, F3, F1);
        req = 4'b0100;
        wait_gnt(idx, g);
        check("t2_gnt", 32'(gnt), 32'h4);
        @(negedge clock);
        req = '0;
        wait_done(d);
        check("t2_done", 32'(done), 32'h4);
        check("t2_result", result, 32'h40000000);
        check("t2_cur_id", 32'(cur_id), 2);

        // round robin from a fresh pointer
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        set_op(0, 1'b0, F1, F1);
        set_op(1, 1'b0, F2, F1);
        set_op(2, 1'b0, F3, F1);
        set_op(3, 1'b0, F4, F1);
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_gnt(idx, g);
            order[r] = idx;
            @(negedge clock);
            if (r == 4) req = '0;
        end
        wait_done(d);
        for (int r = 0; r < 5; r++) check($sformatf("rr_order%0d", r), order[r], exp_rr[r]);
        check("rr_result", result, 32'h40000000);
        check("rr_count", 32'(op_count), 5);

        // fairness: serve 1, then 0 and 1 compete
        @(negedge clock);
        req = 4'b0010;
        wait_gnt(idx, g);
        check("fair_first", 32'(gnt), 32'h2);
        @(negedge clock);
        req = '0;
        wait_done(d);
        @(negedge clock);
        req = 4'b0011;
        wait_gnt(idx, g);
        check("fair_next0", 32'(gnt), 32'h1);
        @(negedge clock);
        wait_gnt(idx, g);
        check("fair_next1", 32'(gnt), 32'h2);
        @(negedge clock);
        req = '0;
        wait_done(d);
        check("fair_count", 32'(op_count), 8);

        // hung unit: abort, then drain until busy released
        @(negedge clock);
        stuck = 1'b1;
        req = 4'b0001;
        wait_gnt(idx, g);
        @(negedge clock);
        req = '0;
        wait_done(d);
        check("tmo_latency", d - g, 64);
        check("tmo_err", 32'(err), 1);
        check("tmo_result", result, 0);
        check("tmo_count", 32'(op_count), 8);
        repeat (10) @(negedge clock);
        #2;
        check("drain_hold", 32'(arb_busy), 1);
        @(negedge clock);
        stuck = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        check("drain_exit", 32'(arb_busy), 0);

        // busy unit blocks arbitration
        @(negedge clock);
        force_busy = 1'b1;
        req = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            #2;
            check("busy_nogrant", 32'(gnt), 0);
            @(negedge clock);
        end
        force_busy = 1'b0;
        wait_gnt(idx, g);
        check("busy_gnt", 32'(gnt), 32'h2);
        @(negedge clock);
        req = '0;

        // reset while waiting on the unit
        repeat (4) @(negedge clock);
        #2;
        check("wait_busy", 32'(arb_busy), 1);
        @(negedge clock);
        reset = 1'b1;
        #2;
        check("rst_mid_busy", 32'(arb_busy), 0);
        check("rst_mid_start", 32'(fpu_start), 0);
        check("rst_mid_a", fpu_a, 0);
        check("rst_mid_cur_id", 32'(cur_id), 0);
        check("rst_mid_count", 32'(op_count), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        req = 4'b1111;
        wait_gnt(idx, g);
        check("rst_first_gnt", 32'(gnt), 32'h1);
        @(negedge clock);
        req = '0;
        wait_done(d);
        check("rst_result", result, 32'h40000000);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
        $fatal(1);
    end

endmodule
